// File: rtl/escalonador_irrigacao.sv
// -----------------------------------------------------------------------------
// escalonador_irrigacao
// Shares one irrigation pump (Bs), the tank inlet valve (Ve), the agrochemical
// pump (Bs_Ag) and the outlet/cleaning valve (Vs) among three requesters
// (sprinkler, drip, agrochemical). Each service runs in a timed window. The
// service windows never overlap. The pump rests after every irrigation window,
// the tank is refilled on demand, and inconsistent level sensors latch an error.
//
// Ports
//   Clock                     in   rising-edge clock
//   Reset                     in   asynchronous, active-low
//   L, M, H                   in   tank level sensors (1 = water at/above)
//   Req_Asp, Req_Got, Req_Ag  in   level-held service requests
//   Ve, Bs, Bs_Ag, Vs         out  inlet valve, irrigation pump,
//                                  agro pump, outlet valve
//   Gnt_Asp, Gnt_Got, Gnt_Ag  out  one-hot service grants
//   Ocupado                   out  state is not OCIOSO
//   E                         out  sticky error flag
//   Estado                    out  current state code
//
// Optional feature: macro LIMPEZA_AUTO_EN.
//   Defined:   a cleaning window (Vs=1) follows every agrochemical window.
//   Undefined: AGRO returns straight to OCIOSO, and Vs stays 0.
// -----------------------------------------------------------------------------
module escalonador_irrigacao #(
    parameter int T_ASP  = 16,
    parameter int T_GOT  = 32,
    parameter int T_AG   = 8,
    parameter int T_LIMP = 8,
    parameter int T_REP  = 4,
    parameter int T_ENCH = 64,
    parameter int CW     = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       H,
    input  logic       M,
    input  logic       L,
    input  logic       Req_Asp,
    input  logic       Req_Got,
    input  logic       Req_Ag,
    output logic       Ve,
    output logic       Bs,
    output logic       Bs_Ag,
    output logic       Vs,
    output logic       Gnt_Asp,
    output logic       Gnt_Got,
    output logic       Gnt_Ag,
    output logic       Ocupado,
    output logic       E,
    output logic [2:0] Estado
);

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        ENCHENDO    = 3'd1,
        ASPERSAO    = 3'd2,
        GOTEJAMENTO = 3'd3,
        AGRO        = 3'd4,
        LIMPEZA     = 3'd5,
        REPOUSO     = 3'd6,
        ERRO        = 3'd7
    } estado_t;

    // Output vector order: {Ve, Bs, Bs_Ag, Vs, Gnt_Asp, Gnt_Got, Gnt_Ag, Ocupado, E}
    estado_t       estado_q, estado_d;
    logic [CW-1:0] timer_q, timer_d;
    logic          rr_got_q, rr_got_d;   // 0: sprinkler has priority, 1: drip
    logic [8:0]    saidas_q, saidas_d;
    logic          req_any_s;
    logic          niveis_ok_s;

    // A physically consistent tank fills from the bottom: L before M before H.
    function automatic logic niveis_validos(input logic [2:0] lmh);
        logic ok;
        case (lmh)
            3'b000, 3'b100, 3'b110, 3'b111: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign req_any_s   = Req_Asp | Req_Got | Req_Ag;
    assign niveis_ok_s = niveis_validos({L, M, H});

    // Next-state, round-robin pointer and timer logic
    always_comb begin
        estado_d = estado_q;
        rr_got_d = rr_got_q;
        if ((estado_q != ERRO) && !niveis_ok_s) begin
            estado_d = ERRO;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    if (!L)                        estado_d = ENCHENDO;
                    else if (req_any_s && !M)      estado_d = ENCHENDO;
                    else if (Req_Ag)               estado_d = AGRO;
                    else if (Req_Asp && Req_Got)   estado_d = rr_got_q ? GOTEJAMENTO : ASPERSAO;
                    else if (Req_Asp)              estado_d = ASPERSAO;
                    else if (Req_Got)              estado_d = GOTEJAMENTO;
                    else                           estado_d = OCIOSO;
                end
                ENCHENDO: begin
                    if (H)                                     estado_d = OCIOSO;
                    else if (timer_q == CW'(T_ENCH - 1))       estado_d = ERRO;
                    else                                       estado_d = ENCHENDO;
                end
                ASPERSAO: begin
                    // Losing water aborts the window without moving the pointer,
                    // so the same requester is served again after refilling.
                    if (!L) begin
                        estado_d = ENCHENDO;
                    end else if (timer_q == CW'(T_ASP - 1)) begin
                        estado_d = REPOUSO;
                        rr_got_d = 1'b1;
                    end else begin
                        estado_d = ASPERSAO;
                    end
                end
                GOTEJAMENTO: begin
                    if (!L) begin
                        estado_d = ENCHENDO;
                    end else if (timer_q == CW'(T_GOT - 1)) begin
                        estado_d = REPOUSO;
                        rr_got_d = 1'b0;
                    end else begin
                        estado_d = GOTEJAMENTO;
                    end
                end
                AGRO: begin
                    if (timer_q == CW'(T_AG - 1)) begin
`ifdef LIMPEZA_AUTO_EN
                        estado_d = LIMPEZA;
`else
                        estado_d = OCIOSO;
`endif
                    end else begin
                        estado_d = AGRO;
                    end
                end
`ifdef LIMPEZA_AUTO_EN
                LIMPEZA: begin
                    if (timer_q == CW'(T_LIMP - 1)) estado_d = OCIOSO;
                    else                            estado_d = LIMPEZA;
                end
`endif
                REPOUSO: begin
                    if (timer_q == CW'(T_REP - 1)) estado_d = REPOUSO == estado_q ? OCIOSO : REPOUSO;
                    else                           estado_d = REPOUSO;
                end
                ERRO:    estado_d = ERRO;
                default: estado_d = OCIOSO;
            endcase
        end
        // The timer counts cycles spent in the current state.
        if (estado_d != estado_q) timer_d = {CW{1'b0}};
        else                      timer_d = timer_q + CW'(1);
    end

    // Output decode from the next state so outputs switch with the state register
    always_comb begin
        saidas_d = 9'b0_0000_0000;
        case (estado_d)
            OCIOSO:      saidas_d = 9'b0_0000_0000;
            ENCHENDO:    saidas_d = 9'b1_0000_0010;
            ASPERSAO:    saidas_d = 9'b0_1001_0010;
            GOTEJAMENTO: saidas_d = 9'b0_1000_1010;
            AGRO:        saidas_d = 9'b0_0100_0110;
`ifdef LIMPEZA_AUTO_EN
            LIMPEZA:     saidas_d = 9'b0_0010_0010;
`endif
            REPOUSO:     saidas_d = 9'b0_0000_0010;
            ERRO:        saidas_d = 9'b0_0000_0011;
            default:     saidas_d = 9'b0_0000_0000;
        endcase
    end

    // State, timer, pointer and output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado_q <= OCIOSO;
            timer_q  <= {CW{1'b0}};
            rr_got_q <= 1'b0;
            saidas_q <= 9'b0_0000_0000;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            rr_got_q <= rr_got_d;
            saidas_q <= saidas_d;
        end
    end

    assign {Ve, Bs, Bs_Ag, Vs, Gnt_Asp, Gnt_Got, Gnt_Ag, Ocupado, E} = saidas_q;
    assign Estado = estado_q;

endmodule
